mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one picorv32-style memory interface between two requesters: port 0, the `riscv` core, and port 1, a DMA/debug master. It sits between the requesters and the single memory/bus slave. It registers and forwards one transaction at a time. A programmable timeout completes stalled transactions with an error so that neither master hangs.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter onto one picorv32-style memory bus,
// one registered transaction at a time with a programmable downstream timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic        busy
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t state, state_nx;
  logic last_grant;
  logic [CW-1:0] cnt, cnt_inc;
  logic any, pick, tmo, fin;

  assign any = m0_valid | m1_valid;
  assign pick = (m0_valid && m1_valid) ? !last_grant : m1_valid;
  assign cnt_inc = cnt + 1'b1;
  // counter hits TIMEOUT on the same edge that closes the transaction
  assign tmo = (TIMEOUT != 0) && !mem_ready && (cnt_inc == TO);
  assign fin = (state == WAIT) && (mem_ready || tmo);
  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = any ? WAIT : IDLE;
    else if (state == WAIT) state_nx = fin ? RESPOND : WAIT;
    else state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      grant <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      if (state == IDLE && any) begin
        grant <= pick;
        last_grant <= pick;
        mem_valid <= 1'b1;
        mem_instr <= pick ? m1_instr : m0_instr;
        mem_addr <= pick ? m1_addr : m0_addr;
        mem_wdata <= pick ? m1_wdata : m0_wdata;
        mem_wstrb <= pick ? m1_wstrb : m0_wstrb;
        cnt <= '0;
      end
      if (state == WAIT && !mem_ready) cnt <= cnt_inc;
      if (fin) begin
        mem_valid <= 1'b0;
        m0_ready <= !grant;
        m1_ready <= grant;
        m0_err <= !grant && !mem_ready;
        m1_err <= grant && !mem_ready;
        if (grant) m1_rdata <= mem_ready ? mem_rdata : '0;
        else m0_rdata <= mem_ready ? mem_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, timing, timeout and reset
// behaviour of mem_arbiter built with TIMEOUT=8.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m0_instr, m0_ready, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        grant, busy;
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Both ports request together; port 0 must win, then port 1 follows.
  task automatic tie_pair(input logic [31:0] a0, input logic [31:0] a1);
    m0_valid = 1; m0_addr = a0; m1_valid = 1; m1_addr = a1;
    cyc();
    chk("tie_grant0", {31'b0, grant}, 0);
    chk("tie_addr0", mem_addr, a0);
    mem_ready = 1; mem_rdata = a0 ^ 32'hFFFF_0000;
    cyc();
    chk("tie_m0_ready", {31'b0, m0_ready}, 1);
    chk("tie_m0_rdata", m0_rdata, a0 ^ 32'hFFFF_0000);
    chk("tie_m1_idle", {31'b0, m1_ready}, 0);
    m0_valid = 0; mem_ready = 0;
    cyc();
    chk("tie_idle_mvalid", {31'b0, mem_valid}, 0);
    cyc();
    chk("tie_grant1", {31'b0, grant}, 1);
    chk("tie_addr1", mem_addr, a1);
    chk("tie_mvalid1", {31'b0, mem_valid}, 1);
    mem_ready = 1; mem_rdata = a1 ^ 32'h0000_FFFF;
    cyc();
    chk("tie_m1_ready", {31'b0, m1_ready}, 1);
    chk("tie_m1_rdata", m1_rdata, a1 ^ 32'h0000_FFFF);
    m1_valid = 0; mem_ready = 0;
    cyc();
  endtask

  initial begin
    reset_n = 0;
    {m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb} = '0;
    {m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb} = '0;
    mem_ready = 0; mem_rdata = '0;
    cyc(); cyc();
    chk("rst_mem_valid", {31'b0, mem_valid}, 0);
    chk("rst_grant", {31'b0, grant}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    reset_n = 1;
    cyc();

    tie_pair(32'h0000_00A0, 32'h0000_00B0);
    tie_pair(32'h0000_00C0, 32'h0000_00D0);
    tie_pair(32'h0000_00E0, 32'h0000_00F0);

    // Zero-wait read by port 0.
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 0;
    cyc();
    chk("rd_mem_valid", {31'b0, mem_valid}, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_wstrb", {28'b0, mem_wstrb}, 0);
    chk("rd_busy", {31'b0, busy}, 1);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("rd_m0_ready", {31'b0, m0_ready}, 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m0_err", {31'b0, m0_err}, 0);
    chk("rd_m1_ready", {31'b0, m1_ready}, 0);
    chk("rd_mem_valid_fall", {31'b0, mem_valid}, 0);
    m0_valid = 0; mem_ready = 0;
    cyc();
    chk("rd_ready_width", {31'b0, m0_ready}, 0);

    // Port 1 write with a 5-cycle slave wait.
    m1_valid = 1; m1_addr = 32'h204; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'b0011;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("wr_mem_valid", {31'b0, mem_valid}, 1);
      chk("wr_mem_addr", mem_addr, 32'h204);
      chk("wr_mem_wdata", mem_wdata, 32'hCAFEF00D);
      chk("wr_mem_wstrb", {28'b0, mem_wstrb}, 4'b0011);
      chk("wr_m1_ready_low", {31'b0, m1_ready}, 0);
    end
    cyc();
    mem_ready = 1; mem_rdata = 32'h7777_7777;
    cyc();
    chk("wr_m1_ready", {31'b0, m1_ready}, 1);
    chk("wr_m1_err", {31'b0, m1_err}, 0);
    chk("wr_grant", {31'b0, grant}, 1);
    chk("wr_m0_ready", {31'b0, m0_ready}, 0);
    m1_valid = 0; mem_ready = 0; m1_wstrb = 0;
    cyc();
    chk("wr_ready_width", {31'b0, m1_ready}, 0);

    // Timeout with mem_ready held low: completion in cycle 9.
    m0_valid = 1; m0_addr = 32'h300; m0_instr = 1;
    cyc();
    chk("to_mem_instr", {31'b0, mem_instr}, 1);
    for (int i = 1; i <= 7; i++) cyc();
    chk("to_c8_ready", {31'b0, m0_ready}, 0);
    chk("to_c8_mvalid", {31'b0, mem_valid}, 1);
    cyc();
    chk("to_ready", {31'b0, m0_ready}, 1);
    chk("to_err", {31'b0, m0_err}, 1);
    chk("to_rdata", m0_rdata, 0);
    chk("to_mvalid", {31'b0, mem_valid}, 0);
    m0_valid = 0; m0_instr = 0;
    cyc();
    chk("to_err_width", {31'b0, m0_err}, 0);

    // mem_ready at the terminal count: ready wins.
    m0_valid = 1; m0_addr = 32'h304;
    for (int i = 1; i <= 8; i++) cyc();
    mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
    cyc();
    chk("tc_ready", {31'b0, m0_ready}, 1);
    chk("tc_err", {31'b0, m0_err}, 0);
    chk("tc_rdata", m0_rdata, 32'h5A5A5A5A);
    m0_valid = 0; mem_ready = 0;
    cyc();

    // Asynchronous reset in the middle of WAIT.
    m1_valid = 1; m1_addr = 32'h400;
    cyc(); cyc();
    chk("ar_pre_busy", {31'b0, busy}, 1);
    #1 reset_n = 0;
    #1;
    chk("ar_mem_valid", {31'b0, mem_valid}, 0);
    chk("ar_mem_addr", mem_addr, 0);
    chk("ar_busy", {31'b0, busy}, 0);
    chk("ar_grant", {31'b0, grant}, 0);
    chk("ar_m1_rdata", m1_rdata, 0);
    chk("ar_m0_rdata", m0_rdata, 0);
    m1_valid = 0;
    cyc();
    chk("ar_m1_no_ready", {31'b0, m1_ready}, 0);
    reset_n = 1;
    cyc();
    m0_valid = 1; m0_addr = 32'h108;
    cyc();
    chk("ar_post_addr", mem_addr, 32'h108);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    cyc();
    chk("ar_post_ready", {31'b0, m0_ready}, 1);
    chk("ar_post_rdata", m0_rdata, 32'h1234_5678);
    chk("ar_post_m1", {31'b0, m1_ready}, 0);
    mem_ready = 0;

    // Port 0 re-requests at once while port 1 is pending: port 1 goes next.
    m0_addr = 32'h404;
    m1_valid = 1; m1_addr = 32'h500;
    cyc();
    chk("rr_idle", {31'b0, busy}, 0);
    cyc();
    chk("rr_grant1", {31'b0, grant}, 1);
    chk("rr_addr1", mem_addr, 32'h500);
    mem_ready = 1; mem_rdata = 32'h0000_0500;
    cyc();
    chk("rr_m1_ready", {31'b0, m1_ready}, 1);
    chk("rr_m0_quiet", {31'b0, m0_ready}, 0);
    m1_valid = 0; mem_ready = 0;
    cyc(); cyc();
    chk("rr_grant0", {31'b0, grant}, 0);
    chk("rr_addr0", mem_addr, 32'h404);
    mem_ready = 1; mem_rdata = 32'h0000_0404;
    cyc();
    chk("rr_m0_ready", {31'b0, m0_ready}, 1);
    chk("rr_m0_rdata", m0_rdata, 32'h0000_0404);
    chk("rr_m1_once", {31'b0, m1_ready}, 0);
    m0_valid = 0; mem_ready = 0;
    cyc(); cyc();
    chk("rr_final_idle", {31'b0, busy}, 0);
    chk("rr_final_mvalid", {31'b0, mem_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
